// File: rtl/ch_frame_arbiter_pkg.sv
// Shared definitions for the two-channel frame arbiter: header sync word,
// FSM state encoding and the frame-size helper.
package ch_frame_arbiter_pkg;

    // Value of header word [63:32]. The top-level HDR_SYNC parameter defaults to this.
    localparam logic [31:0] HDR_SYNC_DEFAULT = 32'hA0AA_A0AA;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2,
        ST_DROP = 2'd3
    } state_e;

    // Frame size in 64-bit words, header included: (LEN + 9) >> 2.
    // Kept at 17 bits so LEN = 16'hFFFF yields 16386 without truncation.
    function automatic logic [16:0] frame_words(input logic [15:0] len);
        logic [16:0] sum;
        sum = {1'b0, len} + 17'd9;
        return {2'b00, sum[16:2]};
    endfunction

endpackage

// File: rtl/ch_frame_arbiter_rr_arb2.sv
// Two-way round-robin selector. With both requests active the channel that
// did not win last time is chosen; with update disabled the last grant holds.
module rr_arb2
    import ch_frame_arbiter_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_grant_i,
    input  logic       en_i,
    output logic       grant_o
);

    // Select the next owner from the pending requests and the previous owner.
    always_comb begin
        grant_o = last_grant_i;
        if (en_i) begin
            case (req_i)
                2'b01:   grant_o = 1'b0;
                2'b10:   grant_o = 1'b1;
                2'b11:   grant_o = ~last_grant_i;
                default: grant_o = last_grant_i;
            endcase
        end else begin
            grant_o = last_grant_i;
        end
    end

endmodule

// File: rtl/ch_frame_arbiter.sv
// Merges framed 64-bit word streams from two FIFOs into one output stream.
// A frame is locked to one channel from header to last word; junk ahead of a
// header is discarded and counted. Reads are throttled by the downstream
// almost-full flag, while words already requested are always forwarded.
module ch_frame_arbiter
    import ch_frame_arbiter_pkg::*;
#(
    parameter logic [31:0] HDR_SYNC = HDR_SYNC_DEFAULT
) (
    input  logic        CLK_250M,
    input  logic        RST,
    input  logic [63:0] dout_CH1,
    input  logic        valid_CH1,
    input  logic        empty_CH1,
    output logic        rd_en_CH1,
    input  logic [63:0] dout_CH2,
    input  logic        valid_CH2,
    input  logic        empty_CH2,
    output logic        rd_en_CH2,
    input  logic        VFIFO_Full,
    output logic [63:0] Data_Out,
    output logic        Valid_Data_Out,
    output logic        Grant_CH,
    output logic [15:0] Frame_Cnt_CH1,
    output logic [15:0] Frame_Cnt_CH2,
    output logic [15:0] Err_Cnt
);

    state_e      state_q, state_d;
    logic        grant_q, grant_d;
    logic        hd_req_q, hd_req_d;   // single header/drop read outstanding
    logic [16:0] wm1_q, wm1_d;         // W-1 of the current frame
    logic [16:0] req_q, req_d;         // body reads issued so far
    logic [16:0] rem_q, rem_d;         // body words still to receive
    logic [15:0] fc1_q, fc1_d;
    logic [15:0] fc2_q, fc2_d;
    logic [15:0] err_q, err_d;
    logic [63:0] dout_q, dout_d;
    logic        vld_q, vld_d;

    logic        g_empty_s, g_valid_s, ng_valid_s;
    logic [63:0] g_dout_s;
    logic        hdr_ok_s;
    logic [16:0] hdr_wm1_s;
    logic        rr_grant_s;
    logic        rd_s;
    logic        frame_done_s;
    logic [1:0]  err_inc_s;

    assign g_empty_s  = grant_q ? empty_CH2 : empty_CH1;
    assign g_valid_s  = grant_q ? valid_CH2 : valid_CH1;
    assign ng_valid_s = grant_q ? valid_CH1 : valid_CH2;
    assign g_dout_s   = grant_q ? dout_CH2  : dout_CH1;
    assign hdr_ok_s   = (g_dout_s[63:32] == HDR_SYNC);
    assign hdr_wm1_s  = frame_words(g_dout_s[15:0]) - 17'd1;

    rr_arb2 u_rr_arb2 (
        .req_i        ({~empty_CH2, ~empty_CH1}),
        .last_grant_i (grant_q),
        .en_i         (state_q == ST_IDLE),
        .grant_o      (rr_grant_s)
    );

    // State register and all datapath/counter registers, synchronous reset.
    always_ff @(posedge CLK_250M) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            grant_q  <= 1'b1;
            hd_req_q <= 1'b0;
            wm1_q    <= 17'd0;
            req_q    <= 17'd0;
            rem_q    <= 17'd0;
            fc1_q    <= 16'd0;
            fc2_q    <= 16'd0;
            err_q    <= 16'd0;
            dout_q   <= 64'd0;
            vld_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            hd_req_q <= hd_req_d;
            wm1_q    <= wm1_d;
            req_q    <= req_d;
            rem_q    <= rem_d;
            fc1_q    <= fc1_d;
            fc2_q    <= fc2_d;
            err_q    <= err_d;
            dout_q   <= dout_d;
            vld_q    <= vld_d;
        end
    end

    // Next state: header checking, body counting, frame and error accounting.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        hd_req_d     = hd_req_q;
        wm1_d        = wm1_q;
        req_d        = req_q;
        rem_d        = rem_q;
        dout_d       = dout_q;
        vld_d        = 1'b0;
        frame_done_s = 1'b0;
        err_inc_s    = ng_valid_s ? 2'd1 : 2'd0;
        case (state_q)
            ST_IDLE: begin
                if (!empty_CH1 || !empty_CH2) begin
                    grant_d  = rr_grant_s;
                    hd_req_d = 1'b0;
                    state_d  = ST_HEAD;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_HEAD, ST_DROP: begin
                if (rd_s) begin
                    hd_req_d = 1'b1;
                end else if (hd_req_q && g_valid_s) begin
                    hd_req_d = 1'b0;
                    if (hdr_ok_s) begin
                        dout_d = g_dout_s;
                        vld_d  = 1'b1;
                        wm1_d  = hdr_wm1_s;
                        rem_d  = hdr_wm1_s;
                        req_d  = 17'd0;
                        if (hdr_wm1_s == 17'd0) begin
                            frame_done_s = 1'b1;
                            state_d      = ST_IDLE;
                        end else begin
                            state_d      = ST_BODY;
                        end
                    end else begin
                        err_inc_s = err_inc_s + 2'd1;
                        state_d   = ST_DROP;
                    end
                end else begin
                    hd_req_d = hd_req_q;
                end
            end
            ST_BODY: begin
                if (rd_s) begin
                    req_d = req_q + 17'd1;
                end else begin
                    req_d = req_q;
                end
                if (g_valid_s) begin
                    dout_d = g_dout_s;
                    vld_d  = 1'b1;
                    rem_d  = rem_q - 17'd1;
                    if (rem_q == 17'd1) begin
                        frame_done_s = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d      = ST_BODY;
                    end
                end else begin
                    rem_d = rem_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        fc1_d = (frame_done_s && !grant_q) ? fc1_q + 16'd1 : fc1_q;
        fc2_d = (frame_done_s &&  grant_q) ? fc2_q + 16'd1 : fc2_q;
        err_d = err_q + {14'd0, err_inc_s};
    end

    // Read strobe for the granted channel; never more than W reads per frame.
    always_comb begin
        rd_s = 1'b0;
        case (state_q)
            ST_HEAD, ST_DROP: rd_s = !hd_req_q && !g_empty_s && !VFIFO_Full;
            ST_BODY:          rd_s = !g_empty_s && !VFIFO_Full && (req_q < wm1_q);
            default:          rd_s = 1'b0;
        endcase
        rd_en_CH1 = rd_s && !grant_q && !RST;
        rd_en_CH2 = rd_s &&  grant_q && !RST;
    end

    assign Data_Out       = dout_q;
    assign Valid_Data_Out = vld_q;
    assign Grant_CH       = grant_q;
    assign Frame_Cnt_CH1  = fc1_q;
    assign Frame_Cnt_CH2  = fc2_q;
    assign Err_Cnt        = err_q;

endmodule

// File: tb/tb_ch_frame_arbiter.sv
// Self-checking bench for ch_frame_arbiter: FIFO models with one-cycle read
// latency, a frame-level reference model, and a per-cycle compare process.
module tb_ch_frame_arbiter;

    localparam logic [31:0] SYNC = 32'hA0AA_A0AA;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] dout1 = 64'd0, dout2 = 64'd0;
    logic        valid1 = 1'b0, valid2 = 1'b0;
    logic        empty1 = 1'b1, empty2 = 1'b1;
    logic        rd1, rd2;
    logic        full_force = 1'b0, full_rand = 1'b0, vfull;
    logic [63:0] data_out;
    logic        vld_out, grant;
    logic [15:0] fc1, fc2, errc;

    assign vfull = full_force | full_rand;

    always #2 clk = ~clk;

    ch_frame_arbiter dut (
        .CLK_250M(clk), .RST(rst),
        .dout_CH1(dout1), .valid_CH1(valid1), .empty_CH1(empty1), .rd_en_CH1(rd1),
        .dout_CH2(dout2), .valid_CH2(valid2), .empty_CH2(empty2), .rd_en_CH2(rd2),
        .VFIFO_Full(vfull), .Data_Out(data_out), .Valid_Data_Out(vld_out),
        .Grant_CH(grant), .Frame_Cnt_CH1(fc1), .Frame_Cnt_CH2(fc2), .Err_Cnt(errc)
    );

    typedef struct {
        logic [63:0] data;
        logic        ch;
        logic [15:0] fc1;
        logic [15:0] fc2;
        logic [15:0] err;
        logic        chk_err;
    } exp_t;

    logic [63:0] q1[$], q2[$];
    exp_t        exp_q[$];
    int          junk_u[2][$];
    int          w_u[2][$];
    logic [63:0] fw[2][$];
    int          exp_fc[2];
    int          exp_err;
    int          rd_cnt[2];
    int          loaded[2];
    int          out_cnt = 0;
    int          errors = 0;
    int          checks = 0;
    logic [63:0] last_data = 64'd0;
    logic        prev_v = 1'b0;
    logic        rand_en = 1'b0;
    int          rand_pct = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // FIFO models: registered read data, valid one cycle after a read.
    always @(posedge clk) begin
        if (rd1 && q1.size() > 0) begin dout1 <= q1.pop_front(); valid1 <= 1'b1; end
        else valid1 <= 1'b0;
        if (rd2 && q2.size() > 0) begin dout2 <= q2.pop_front(); valid2 <= 1'b1; end
        else valid2 <= 1'b0;
        empty1 <= (q1.size() == 0);
        empty2 <= (q2.size() == 0);
    end

    // Random downstream back-pressure.
    always @(posedge clk) begin
        #1;
        full_rand = rand_en ? ($urandom_range(0, 99) < rand_pct) : 1'b0;
    end

    // Compare process: read rules every cycle, output stream against the model.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (rd1) rd_cnt[0]++;
            if (rd2) rd_cnt[1]++;
            if (rd1 || rd2) begin
                chk("rd_while_full", 64'(vfull), 64'd0);
                chk("rd_on_empty", 64'(rd1 ? empty1 : empty2), 64'd0);
                chk("rd_both", 64'(rd1 & rd2), 64'd0);
                chk("rd_not_granted", 64'(rd2), 64'(grant));
            end
            if (vld_out) begin
                out_cnt++;
                chk("latency", 64'(prev_v), 64'd1);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_out: got %h expected no word", data_out);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", data_out, e.data);
                    chk("grant", 64'(grant), 64'(e.ch));
                    chk("fc1", 64'(fc1), 64'(e.fc1));
                    chk("fc2", 64'(fc2), 64'(e.fc2));
                    if (e.chk_err) chk("err", 64'(errc), 64'(e.err));
                end
            end else begin
                chk("data_hold", data_out, last_data);
            end
            last_data = data_out;
        end else begin
            last_data = 64'd0;
        end
        prev_v = valid1 | valid2;
    end

    task automatic push_fifo(input int c, input logic [63:0] wd);
        if (c == 0) q1.push_back(wd); else q2.push_back(wd);
    endtask

    // Append junk words then one frame of LEN to channel c, recording it for the model.
    task automatic add_unit(input int c, input int junk, input logic [15:0] len,
                            input bit fixed_junk, input bit body_sync);
        int w;
        logic [63:0] wd;
        w = (int'(len) + 9) / 4;
        for (int k = 0; k < junk; k++) begin
            wd = fixed_junk ? 64'h1234_1234_1234_1234 : {16'h1234, 16'($urandom), $urandom};
            push_fifo(c, wd);
        end
        wd = {SYNC, 16'($urandom), len};
        push_fifo(c, wd); fw[c].push_back(wd);
        for (int k = 1; k < w; k++) begin
            if (body_sync && $urandom_range(0, 3) == 0) wd = {SYNC, $urandom};
            else wd = {16'h5A5A, 16'($urandom), $urandom};
            push_fifo(c, wd); fw[c].push_back(wd);
        end
        junk_u[c].push_back(junk);
        w_u[c].push_back(w);
        loaded[c] += junk + w;
    endtask

    // Frame-level model: alternate channels while both have frames, starting at CH1.
    task automatic build_expect(input bit chk_err);
        int ui[2]; int wi[2]; int fc[2];
        int last, c, err, w;
        exp_t e;
        ui = '{0, 0}; wi = '{0, 0}; fc = '{0, 0};
        last = 1; err = 0;
        while (ui[0] < junk_u[0].size() || ui[1] < junk_u[1].size()) begin
            if (ui[0] < junk_u[0].size() && ui[1] < junk_u[1].size()) c = 1 - last;
            else if (ui[0] < junk_u[0].size()) c = 0;
            else c = 1;
            last = c;
            err += junk_u[c][ui[c]];
            w = w_u[c][ui[c]];
            for (int k = 0; k < w; k++) begin
                if (k == w - 1) fc[c]++;
                e.data = fw[c][wi[c]]; wi[c]++;
                e.ch = (c == 1);
                e.fc1 = 16'(fc[0]); e.fc2 = 16'(fc[1]); e.err = 16'(err);
                e.chk_err = chk_err;
                exp_q.push_back(e);
            end
            ui[c]++;
        end
        exp_fc = fc; exp_err = err;
        for (int k = 0; k < 2; k++) begin junk_u[k].delete(); w_u[k].delete(); fw[k].delete(); end
    endtask

    // One-cycle reset pulse, checking every output while reset is applied.
    task automatic do_reset();
        @(posedge clk); #1; rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_valid", 64'(vld_out), 64'd0);
        chk("rst_data", data_out, 64'd0);
        chk("rst_grant", 64'(grant), 64'd1);
        chk("rst_fc1", 64'(fc1), 64'd0);
        chk("rst_fc2", 64'(fc2), 64'd0);
        chk("rst_err", 64'(errc), 64'd0);
        chk("rst_rd", 64'({rd1, rd2}), 64'd0);
        rst = 1'b0;
    endtask

    task automatic start_scn();
        do_reset();
        q1.delete(); q2.delete(); exp_q.delete();
        rd_cnt = '{0, 0}; loaded = '{0, 0}; out_cnt = 0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int n = 0;
        while (exp_q.size() > 0 && n < budget) begin @(posedge clk); n++; end
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL %s_timeout: got %0d words outstanding expected 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic end_checks(input string name, input bit chk_reads, input bit chk_err);
        chk({name, "_fc1"}, 64'(fc1), 64'(exp_fc[0]));
        chk({name, "_fc2"}, 64'(fc2), 64'(exp_fc[1]));
        if (chk_err) chk({name, "_err"}, 64'(errc), 64'(exp_err));
        if (chk_reads) begin
            chk({name, "_reads1"}, 64'(rd_cnt[0]), 64'(loaded[0]));
            chk({name, "_reads2"}, 64'(rd_cnt[1]), 64'(loaded[1]));
            chk({name, "_left"}, 64'(q1.size() + q2.size()), 64'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int snap, n;

        // Single short frame on CH1.
        start_scn();
        add_unit(0, 0, 16'd2, 1'b0, 1'b0);
        build_expect(1'b1);
        wait_done(200, "single");
        end_checks("single", 1'b1, 1'b1);
        chk("single_out", 64'(out_cnt), 64'd2);
        chk("single_fc1", 64'(fc1), 64'd1);
        chk("single_grant", 64'(grant), 64'd0);

        // Both channels with two W=4 frames: strict alternation.
        start_scn();
        add_unit(0, 0, 16'd10, 1'b0, 1'b1); add_unit(0, 0, 16'd10, 1'b0, 1'b1);
        add_unit(1, 0, 16'd10, 1'b0, 1'b1); add_unit(1, 0, 16'd10, 1'b0, 1'b1);
        build_expect(1'b1);
        wait_done(400, "rr");
        end_checks("rr", 1'b1, 1'b1);
        chk("rr_fc1", 64'(fc1), 64'd2);
        chk("rr_fc2", 64'(fc2), 64'd2);

        // Three junk words ahead of a CH2 frame.
        start_scn();
        add_unit(1, 3, 16'd2, 1'b1, 1'b0);
        build_expect(1'b1);
        wait_done(300, "junk");
        end_checks("junk", 1'b1, 1'b1);
        chk("junk_err", 64'(errc), 64'd3);
        chk("junk_fc2", 64'(fc2), 64'd1);

        // Back-pressure held for 20 cycles during a W=4 body.
        start_scn();
        add_unit(0, 0, 16'd10, 1'b0, 1'b0);
        build_expect(1'b1);
        n = 0;
        while (exp_q.size() > 3 && n < 100) begin @(posedge clk); n++; end
        #1; full_force = 1'b1; snap = rd_cnt[0];
        repeat (20) @(posedge clk);
        #1;
        chk("hold_no_rd", 64'(rd_cnt[0] - snap), 64'd0);
        chk("hold_inflight", 64'(exp_q.size()), 64'd2);
        full_force = 1'b0;
        wait_done(200, "hold");
        end_checks("hold", 1'b1, 1'b1);
        chk("hold_reads", 64'(rd_cnt[0]), 64'd4);
        chk("hold_out", 64'(out_cnt), 64'd4);

        // Reset in the middle of a long body, then a clean frame resynchronises.
        start_scn();
        add_unit(0, 0, 16'd100, 1'b0, 1'b0);
        add_unit(0, 0, 16'd2, 1'b0, 1'b0);
        build_expect(1'b0);
        n = 0;
        while (exp_q.size() > 27 && n < 200) begin @(posedge clk); n++; end
        do_reset();
        while (exp_q.size() > 2) void'(exp_q.pop_front());
        exp_q[0].fc1 = 16'd0;
        exp_q[1].fc1 = 16'd1;
        wait_done(500, "midrst");
        chk("midrst_fc1", 64'(fc1), 64'd1);
        chk("midrst_grant", 64'(grant), 64'd0);

        // Maximum frame length on CH2 with light random back-pressure.
        start_scn();
        rand_pct = 10; rand_en = 1'b1;
        add_unit(1, 0, 16'hFFFF, 1'b0, 1'b1);
        build_expect(1'b1);
        wait_done(40000, "maxlen");
        rand_en = 1'b0;
        end_checks("maxlen", 1'b1, 1'b1);
        chk("maxlen_out", 64'(out_cnt), 64'd16386);
        chk("maxlen_fc2", 64'(fc2), 64'd1);

        // Randomised mixes of junk and frames on both channels.
        for (int r = 0; r < 6; r++) begin
            start_scn();
            rand_pct = 30; rand_en = 1'b1;
            for (int c = 0; c < 2; c++) begin
                n = $urandom_range(1, 5);
                for (int u = 0; u < n; u++)
                    add_unit(c, $urandom_range(0, 2), 16'($urandom_range(0, 40)), 1'b0, 1'b1);
            end
            build_expect(1'b1);
            wait_done(6000, "rand");
            rand_en = 1'b0;
            end_checks("rand", 1'b1, 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ch_frame_arbiter.md
CH_FRAME_ARBITER -- requirements
Module: ch_frame_arbiter

Interface
REQ-001 SHALL have these ports (clock and reset first):
  CLK_250M  in  1  sole clock; all logic on its rising edge
  RST  in  1  synchronous, active-high reset
  dout_CH1  in  64  CH1 FIFO read data; first-received 16-bit word in [63:48]
  valid_CH1  in  1  dout_CH1 holds a word read by rd_en_CH1
  empty_CH1  in  1  CH1 FIFO empty
  rd_en_CH1  out  1  CH1 FIFO read strobe
  dout_CH2 / valid_CH2 / empty_CH2 / rd_en_CH2  as CH1, for CH2
  VFIFO_Full  in  1  downstream almost-full; at least 4 words of margin remain
  Data_Out  out  64  merged frame word
  Valid_Data_Out  out  1  Data_Out qualifier
  Grant_CH  out  1  0=CH1, 1=CH2; channel owning the current/last frame
  Frame_Cnt_CH1, Frame_Cnt_CH2  out  16  frames forwarded per channel, wrapping
  Err_Cnt  out  16  discarded non-header words, wrapping
REQ-002 SHALL have this parameter: HDR_SYNC, 32'hA0AA_A0AA, required value of header word [63:32].

Function
REQ-003 SHALL define a frame header word as [63:32]==HDR_SYNC, [31:16]=kind, [15:0]=LEN.
REQ-004 SHALL define frame size W = (LEN + 9) >> 2 words of 64 bits, header included; W SHALL be computed in 17 bits with no truncation (LEN=16'hFFFF gives W=16386).
REQ-005 SHALL implement states IDLE, HEAD, BODY and DROP.
REQ-006 IDLE: a channel is pending when its empty input is 0. SHALL grant the single pending channel; when both are pending, SHALL grant the channel other than Grant_CH (round-robin). Grant_CH updates on entry to HEAD.
REQ-007 HEAD: SHALL pulse the granted rd_en for exactly one cycle, but only while its empty=0 and VFIFO_Full=0. SHALL then wait for valid.
REQ-008 HEAD, on valid with a good header: SHALL forward the word, load the remaining count with W-1, and go to BODY. If W-1==0, SHALL instead increment the frame counter and go to IDLE.
REQ-009 HEAD, on valid with a bad header: SHALL drop the word, increment Err_Cnt, and go to DROP.
REQ-010 DROP: SHALL read the same channel one word at a time with HEAD gating. Each non-header word SHALL be dropped and counted in Err_Cnt. The first good header SHALL be handled exactly as in REQ-008.
REQ-011 BODY: SHALL assert rd_en on the granted channel while empty=0, VFIFO_Full=0, and requested < W-1. Back-to-back cycles are allowed.
REQ-012 BODY: SHALL forward every valid word, regardless of VFIFO_Full. After the last word is received, SHALL increment the channel's frame counter and return to IDLE.
REQ-013 BODY: SHALL NOT check header contents; frames are never interleaved between channels.
REQ-014 SHALL hold rd_en of the non-granted channel at 0 at all times.
REQ-015 SHALL ignore valid on the non-granted channel and count it in Err_Cnt.
REQ-016 Latency: Data_Out and Valid_Data_Out SHALL be registered, exactly 1 cycle after valid.
REQ-017 Valid_Data_Out SHALL be a 1-cycle pulse per word. Data_Out SHALL hold its value when Valid_Data_Out=0.
REQ-018 Counters SHALL wrap from 16'hFFFF to 0 without saturation.
REQ-019 SHALL NOT issue more reads per frame than W, including when VFIFO_Full toggles mid-frame.

Reset
REQ-020 While RST=1: SHALL force state=IDLE, rd_en_CH1=rd_en_CH2=0, Valid_Data_Out=0, Data_Out=0, Grant_CH=1 (so CH1 wins first contention), and all counters=0.
REQ-021 Reset mid-frame SHALL abandon the frame with no further output. Words still in flight SHALL be ignored. The next word read SHALL go through HEAD checking, which resynchronises through DROP.

Structure
REQ-022 The shared package SHALL hold HDR_SYNC, the state encoding, and a frame-size function implementing REQ-004.
REQ-023 Round-robin selection SHALL live in one sub-module, rr_arb2: request[1:0], last grant, and update enable in; grant out.

Verification
REQ-024 CH1 only, header LEN=2 (W=2), 1 body word -> 2 output words, 1 cycle after each valid; Frame_Cnt_CH1=1; Grant_CH=0.
REQ-025 Both channels hold LEN=10 frames (W=4) -> output order CH1,CH2,CH1,CH2 with 4 contiguous words each, never interleaved; each Frame_Cnt=2.
REQ-026 CH2 starts with 3 junk words (16'h1234 patterns), then a LEN=2 header -> Err_Cnt=3, then the frame is forwarded; Frame_Cnt_CH2=1.
REQ-027 VFIFO_Full held high for 20 cycles during BODY of a W=4 frame -> no rd_en during the hold; in-flight word still forwarded; exactly 4 reads total.
REQ-028 RST pulsed for 1 cycle during BODY -> next cycle all outputs 0 and state IDLE; the next good header is forwarded normally.
REQ-029 LEN=16'hFFFF -> 16386 words forwarded; Frame_Cnt increments once, exactly after the last word.
